mem_access_stage: RTL

Pipeline MEM stage wrapped around the byte-addressed data memory: holds the EX/MEM pipeline register, drives the memory's read/write ports with address, width code and store data, then formats returned load data (byte/half/word, signed/unsigned) into the MEM/WB register. Misaligned or out-of-range accesses are suppressed and flagged. A debug read port borrows the memory read path while the CPU is halted.

---
 rtl/mem_access_stage_pkg.sv | 12 +
 rtl/mem_access_stage_load_formatter.sv | 38 +++
 rtl/mem_access_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared widths and memory width codes for the MEM stage
package mem_access_stage_pkg;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;

    // Width codes carried from decode to the memory ports; 2'b10 is illegal.
    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b11;

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// rtl/mem_access_stage_load_formatter.sv - load width/sign extension and alignment check
module load_formatter #(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] i_data,
    input  logic [1:0]         i_width,
    input  logic               i_unsigned,
    input  logic [1:0]         i_addr_lo,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_misaligned
);
    import mem_access_stage_pkg::*;

    // Memory returns the addressed item right-justified; extend it to the datapath width.
    always_comb begin
        o_data       = i_data;
        o_misaligned = 1'b0;
        case (i_width)
            W_BYTE: begin
                o_data = i_unsigned ? {{(NB_DATA-8){1'b0}}, i_data[7:0]}
                                    : {{(NB_DATA-8){i_data[7]}}, i_data[7:0]};
            end
            W_HALF: begin
                o_data = i_unsigned ? {{(NB_DATA-16){1'b0}}, i_data[15:0]}
                                    : {{(NB_DATA-16){i_data[15]}}, i_data[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            W_WORD: begin
                o_misaligned = |i_addr_lo;
            end
            default: begin
                o_data       = '0;
                o_misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - EX/MEM register, data memory port drive, load formatting into MEM/WB
module mem_access_stage #(
    parameter int NB_DATA    = 32,
    parameter int N_ADDRESS  = 64,
    parameter int NB_ADDRESS = $clog2(N_ADDRESS),
    parameter int NB_REG     = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [NB_DATA-1:0]    i_ex_alu_result,
    input  logic [NB_DATA-1:0]    i_ex_store_data,
    input  logic                  i_ex_mem_read,
    input  logic                  i_ex_mem_write,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_to_reg,
    input  logic [1:0]            i_ex_width,
    input  logic                  i_ex_unsigned,
    input  logic [NB_REG-1:0]     i_ex_rd,
    input  logic                  i_dbg_en,
    input  logic [NB_ADDRESS-1:0] i_dbg_addr,
    output logic [NB_ADDRESS-1:0] o_mem_r_addr,
    output logic [NB_ADDRESS-1:0] o_mem_w_addr,
    output logic                  o_mem_r_en,
    output logic                  o_mem_w_en,
    output logic [1:0]            o_mem_r_addressing,
    output logic [1:0]            o_mem_w_addressing,
    output logic [NB_DATA-1:0]    o_mem_w_data,
    input  logic [NB_DATA-1:0]    i_mem_r_data,
    output logic [NB_DATA-1:0]    o_dbg_data,
    output logic [NB_DATA-1:0]    o_wb_data,
    output logic [NB_DATA-1:0]    o_wb_alu_result,
    output logic [NB_REG-1:0]     o_wb_rd,
    output logic                  o_wb_reg_write,
    output logic                  o_wb_mem_to_reg,
    output logic                  o_wb_exc,
    output logic                  o_exc_sticky
);
    import mem_access_stage_pkg::*;

    logic [NB_DATA-1:0] r_alu_result;
    logic [NB_DATA-1:0] r_store_data;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_reg_write;
    logic               r_mem_to_reg;
    logic [1:0]         r_width;
    logic               r_unsigned;
    logic [NB_REG-1:0]  r_rd;

    logic [NB_DATA-1:0] r_wb_data;
    logic [NB_DATA-1:0] r_wb_alu_result;
    logic [NB_REG-1:0]  r_wb_rd;
    logic               r_wb_reg_write;
    logic               r_wb_mem_to_reg;
    logic               r_wb_exc;
    logic               r_exc_sticky;

    logic               w_hold;
    logic               w_misaligned;
    logic               w_out_of_range;
    logic               w_fault;
    logic [NB_DATA-1:0] w_fmt_in;
    logic [NB_DATA-1:0] w_fmt_data;
    logic [NB_DATA-1:0] w_load_data;

    // A debug read halts the pipeline so an in-flight store is not lost while the port is borrowed.
    assign w_hold         = i_stall | i_dbg_en;
    assign w_out_of_range = |r_alu_result[NB_DATA-1:NB_ADDRESS];
    assign w_fault        = (r_mem_read | r_mem_write) & (w_misaligned | w_out_of_range);
    assign w_fmt_in       = i_dbg_en ? '0 : i_mem_r_data;
    assign w_load_data    = (r_mem_read & !w_fault) ? w_fmt_data : '0;

    load_formatter #(.NB_DATA(NB_DATA)) u_load_formatter (
        .i_data       (w_fmt_in),
        .i_width      (r_width),
        .i_unsigned   (r_unsigned),
        .i_addr_lo    (r_alu_result[1:0]),
        .o_data       (w_fmt_data),
        .o_misaligned (w_misaligned)
    );

    assign o_mem_w_addr       = r_alu_result[NB_ADDRESS-1:0];
    assign o_mem_w_addressing = r_width;
    assign o_mem_w_data       = r_store_data;
    assign o_mem_w_en         = r_mem_write & !w_fault & !i_stall & !i_dbg_en;
    assign o_mem_r_addr       = i_dbg_en ? (i_dbg_addr & ~NB_ADDRESS'(3)) : r_alu_result[NB_ADDRESS-1:0];
    assign o_mem_r_addressing = i_dbg_en ? W_WORD : r_width;
    assign o_mem_r_en         = i_dbg_en | (r_mem_read & !w_fault);
    assign o_dbg_data         = i_dbg_en ? i_mem_r_data : '0;

    assign o_wb_data          = r_wb_data;
    assign o_wb_alu_result    = r_wb_alu_result;
    assign o_wb_rd            = r_wb_rd;
    assign o_wb_reg_write     = r_wb_reg_write;
    assign o_wb_mem_to_reg    = r_wb_mem_to_reg;
    assign o_wb_exc           = r_wb_exc;
    assign o_exc_sticky       = r_exc_sticky;

    // EX/MEM register: flush inserts a bubble even while held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_result <= '0;
            r_store_data <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_width      <= W_WORD;
            r_unsigned   <= 1'b0;
            r_rd         <= '0;
        end else if (i_flush) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!w_hold) begin
            r_alu_result <= i_ex_alu_result;
            r_store_data <= i_ex_store_data;
            r_mem_read   <= i_ex_mem_read;
            r_mem_write  <= i_ex_mem_write;
            r_reg_write  <= i_ex_reg_write;
            r_mem_to_reg <= i_ex_mem_to_reg;
            r_width      <= i_ex_width;
            r_unsigned   <= i_ex_unsigned;
            r_rd         <= i_ex_rd;
        end
    end

    // MEM/WB register: faulting accesses retire with no register write and the exception bit set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_data       <= '0;
            r_wb_alu_result <= '0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_exc        <= 1'b0;
        end else if (!w_hold) begin
            r_wb_data       <= w_load_data;
            r_wb_alu_result <= r_alu_result;
            r_wb_rd         <= r_rd;
            r_wb_reg_write  <= r_reg_write & !w_fault;
            r_wb_mem_to_reg <= r_mem_to_reg;
            r_wb_exc        <= w_fault;
        end
    end

    // Sticky exception flag, set alongside the first retired fault.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exc_sticky <= 1'b0;
        end else if (!w_hold && w_fault) begin
            r_exc_sticky <= 1'b1;
        end
    end

endmodule
